// File: rtl/rb_pkg.sv
// Shared constants and types for the row-buffer writer/reader pair.
package rb_pkg;
   localparam int PIX_W      = 8;
   localparam int WORD_W     = 32;
   localparam int LANES      = WORD_W / PIX_W;
   localparam int LANE_W     = $clog2(LANES);
   localparam int ADDR_W     = 9;
   localparam int LEN_W      = 10;
   localparam int FIFO_DEPTH = 2;
   localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} rb_state_e;

   // Lane 0 is the least significant byte of the word.
   function automatic logic [PIX_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] idx);
      return word[idx*PIX_W +: PIX_W];
   endfunction
endpackage

// File: rtl/rb_row_reader_if.sv
// Pixel stream from the row-buffer reader to the neighbourhood window stage.
interface rb_row_reader_if;
   import rb_pkg::*;

   logic [PIX_W-1:0] pix_data;
   logic             pix_valid;
   logic             pix_ready;
   logic             pix_last;

   modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
   modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/rb_word_fifo.sv
// Small synchronous word FIFO with occupancy count, used to absorb BRAM latency and backpressure.
module rb_word_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
endmodule

// File: rtl/rb_row_reader.sv
// Row-buffer port-B reader: fetches a wrapped run of packed words and streams them as pixels.
// Defining RB_STALL_CNT_EN adds the stall_cnt output (RUN cycles with pix_valid & !pix_ready).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads and streaming pixels
// FIN   | one-cycle done pulse, start ignored
module rb_row_reader
   import rb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   output logic              en_b,
   output logic [ADDR_W-1:0] addr_b,
   input  logic [WORD_W-1:0] dout_b,
   rb_row_reader_if.master   pix
`ifdef RB_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   rb_state_e         state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              en_b_q, en_b_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
   logic [LEN_W-1:0]  word_rem_q, word_rem_d;
   logic              inflight_q, inflight_d;
   logic [LANE_W-1:0] lane_q, lane_d;
`ifdef RB_STALL_CNT_EN
   logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

   logic [WORD_W-1:0] fifo_head;
   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_empty;
   logic              pix_valid;
   logic              last_lane;
   logic              hs;
   logic              pop;
   logic              push;
   logic              pix_last;
   int                fcnt_nxt;

   // The space check on issue guarantees room, so the returning word is always pushed.
   assign push      = inflight_q;
   assign pix_valid = !fifo_empty;
   assign last_lane = (lane_q == LANE_W'(LANES - 1));
   assign hs        = pix_valid && pix.pix_ready;
   assign pop       = hs && last_lane;
   assign pix_last  = pix_valid && last_lane && (word_rem_q == LEN_W'(1));

   rb_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (dout_b),
      .pop   (pop),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      addr_b_d    = addr_b_q;
      issue_rem_d = issue_rem_q;
      word_rem_d  = word_rem_q;
      lane_d      = lane_q;
      inflight_d  = en_b_q;
      if (en_b_q) begin
         addr_b_d    = addr_b_q + ADDR_W'(1);
         issue_rem_d = issue_rem_q - LEN_W'(1);
      end
      if (hs) begin
         lane_d = last_lane ? '0 : lane_q + LANE_W'(1);
         if (last_lane) word_rem_d = word_rem_q - LEN_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  state_d     = RUN;
                  addr_b_d    = base_addr;
                  issue_rem_d = num_words;
                  word_rem_d  = num_words;
                  lane_d      = '0;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN:     if (hs && pix_last) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // en_b is registered, so occupancy is predicted for the coming cycle.
      fcnt_nxt = int'(fifo_count) + int'(push) - int'(pop);
      en_b_d   = (state_d == RUN) && (issue_rem_d != '0) &&
                 ((fcnt_nxt + int'(inflight_d)) < FIFO_DEPTH);
      busy_d   = (state_d == RUN);
      done_d   = (state_d == FIN);
`ifdef RB_STALL_CNT_EN
      stall_cnt_d = stall_cnt_q;
      if (state_q == IDLE && start) begin
         stall_cnt_d = '0;
      end else if (state_q == RUN && pix_valid && !pix.pix_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_b_q      <= 1'b0;
         addr_b_q    <= '0;
         issue_rem_q <= '0;
         word_rem_q  <= '0;
         inflight_q  <= 1'b0;
         lane_q      <= '0;
`ifdef RB_STALL_CNT_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         en_b_q      <= en_b_d;
         addr_b_q    <= addr_b_d;
         issue_rem_q <= issue_rem_d;
         word_rem_q  <= word_rem_d;
         inflight_q  <= inflight_d;
         lane_q      <= lane_d;
`ifdef RB_STALL_CNT_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign en_b          = en_b_q;
   assign addr_b        = addr_b_q;
   assign pix.pix_valid = pix_valid;
   assign pix.pix_data  = lane_sel(fifo_head, lane_q);
   assign pix.pix_last  = pix_last;
`ifdef RB_STALL_CNT_EN
   assign stall_cnt     = stall_cnt_q;
`endif
endmodule

// File: tb/tb_rb_row_reader.sv
// Bench for rb_row_reader: BRAM port-B model, pixel-stream reference model and directed commands.
module tb_rb_row_reader;
   import rb_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  num_words;
   logic              busy;
   logic              done;
   logic              en_b;
   logic [ADDR_W-1:0] addr_b;
   logic [WORD_W-1:0] dout_b = '0;
`ifdef RB_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   rb_row_reader_if pif ();

   rb_row_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .en_b      (en_b),
      .addr_b    (addr_b),
      .dout_b    (dout_b),
      .pix       (pif)
`ifdef RB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [512];
   always @(posedge clk) if (en_b) dout_b <= mem[addr_b];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected pixel bytes per command and expected busy/done per cycle.
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          addr_log[$];
   logic        m_busy = 1'b0, m_done = 1'b0;
   int          m_base, m_num, issued, popped, hs_cnt;
   int          cyc = 0, acc_cyc = 0, done_cyc = 0;
   bit          first_pend = 1'b0;
   int          m_stall = 0;

   always @(negedge clk) begin
      logic nb, nd, hs;
      logic [31:0] w;
      cyc++;
      if (rst) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_en_b", en_b, 0);
         chk("rst_addr_b", addr_b, 0);
         chk("rst_pix_valid", pif.pix_valid, 0);
         chk("rst_pix_last", pif.pix_last, 0);
         chk("rst_pix_data", pif.pix_data, 0);
`ifdef RB_STALL_CNT_EN
         chk("rst_stall_cnt", stall_cnt, 0);
`endif
         m_busy = 0; m_done = 0; exp_q.delete(); issued = 0; popped = 0; hs_cnt = 0;
         m_stall = 0; first_pend = 0;
      end else begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         if (done) done_cyc = cyc;
`ifdef RB_STALL_CNT_EN
         chk("stall_cnt", stall_cnt, m_stall);
`endif
         hs = pif.pix_valid && pif.pix_ready;
         if (pif.pix_valid) begin
            chk("pix_has_model", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               chk("pix_data", pif.pix_data, exp_q[0]);
               chk("pix_last", pif.pix_last, exp_q.size() == 1);
               if (first_pend) chk("first_valid_lat", cyc - acc_cyc, 3);
               first_pend = 0;
            end
         end else begin
            chk("pix_last_idle", pif.pix_last, 0);
         end
         if (en_b) begin
            chk("en_b_allowed", m_busy && (issued < m_num), 1);
            chk("addr_b", addr_b, (m_base + issued) % 512);
            chk("en_b_space", (issued - popped) < 2, 1);
            if (issued == 0) chk("en_b_lat", cyc - acc_cyc, 1);
            addr_log.push_back(int'(addr_b));
         end
         nb = m_busy; nd = 0;
         if (en_b) issued++;
         if (m_busy && pif.pix_valid && !pif.pix_ready && m_stall < 16'hFFFF) m_stall++;
         if (hs && exp_q.size() > 0) begin
            got_q.push_back(pif.pix_data);
            void'(exp_q.pop_front());
            hs_cnt++;
            if (hs_cnt % 4 == 0) popped++;
            if (exp_q.size() == 0 && m_busy) begin nb = 0; nd = 1; end
         end
         if (start && !m_busy && !m_done) begin
            acc_cyc = cyc; m_stall = 0;
            m_base = int'(base_addr); m_num = int'(num_words);
            issued = 0; popped = 0; hs_cnt = 0;
            if (num_words != 0) begin
               nb = 1; first_pend = 1;
               for (int i = 0; i < m_num; i++) begin
                  w = mem[(m_base + i) % 512];
                  for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
               end
            end else begin
               nd = 1;
            end
         end
         m_busy = nb; m_done = nd;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input int b, input int n);
      start = 1'b1; base_addr = ADDR_W'(b); num_words = LEN_W'(n);
      tick();
      start = 1'b0;
   endtask

   // mode 0: pix_ready held at 1; mode 1: pix_ready pattern 1,0,0,1
   task automatic run_to_done(input int mode, input int max);
      int k = 0;
      while (!done && k < max) begin
         if (mode == 1) pif.pix_ready = (k % 4 == 0) || (k % 4 == 3);
         tick();
         k++;
      end
      chk("done_seen", done, 1);
      pif.pix_ready = 1'b1;
   endtask

   task automatic chk_pixels(input string nm, input logic [7:0] exp[$]);
      chk({nm, "_len"}, got_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got_q.size(); i++) chk(nm, got_q[i], exp[i]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
      $fatal(1);
   end

   initial begin
      logic [7:0] seq[$];
      for (int j = 0; j < 512; j++) mem[j] = 32'hE000_0000 | j;
      for (int j = 0; j < 4; j++) mem[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      mem[511] = 32'hDDCC_BBAA;

      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; pif.pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Basic read, plus a start while busy and a start during FIN, both ignored.
      got_q.delete();
      send(0, 4);
      repeat (4) tick();
      send(8, 1);
      run_to_done(0, 100);
      send(5, 1);
      repeat (3) tick();
      chk("fin_start_ignored", busy, 0);
      seq.delete();
      for (int i = 0; i < 16; i++) seq.push_back(8'(i));
      chk_pixels("basic_pix", seq);
      chk("basic_done_lat", done_cyc - acc_cyc, 19);

      // Backpressure with pix_ready 1,0,0,1
      got_q.delete();
      send(0, 4);
      run_to_done(1, 200);
      tick();
      chk_pixels("bp_pix", seq);

      // Wrap-around from word 511 to word 0
      got_q.delete(); addr_log.delete();
      send(511, 2);
      run_to_done(0, 100);
      tick();
      chk_pixels("wrap_pix", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h01, 8'h02, 8'h03});
      chk("wrap_addr_n", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         chk("wrap_addr0", addr_log[0], 511);
         chk("wrap_addr1", addr_log[1], 0);
      end

      // Zero length
      send(0, 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_done_clear", done, 0);
      tick();

      // Reset mid-run after pixel 5, then a clean one-word command
      got_q.delete();
      send(0, 4);
      for (int k = 0; k < 100 && got_q.size() < 6; k++) tick();
      chk("mid_reached_pix5", got_q.size() >= 6, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", pif.pix_valid, 0);
      chk("mid_rst_en_b", en_b, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) tick();
      chk("mid_no_done", done, 0);
      got_q.delete();
      send(2, 1);
      run_to_done(0, 100);
      tick();
      chk_pixels("after_rst_pix", '{8'd8, 8'd9, 8'd10, 8'd11});

`ifdef RB_STALL_CNT_EN
      // Seven backpressured cycles while a pixel is waiting
      pif.pix_ready = 1'b0;
      send(0, 1);
      for (int k = 0; k < 10 && !pif.pix_valid; k++) tick();
      chk("stall_valid_seen", pif.pix_valid, 1);
      repeat (7) tick();
      pif.pix_ready = 1'b1;
      run_to_done(0, 50);
      chk("stall_cnt_at_done", stall_cnt, 7);
      repeat (2) tick();
      chk("stall_cnt_hold", stall_cnt, 7);
`endif

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
